alu_sequencer: RTL and testbench

Instruction-level controller for the 16-bit combinational ALU. Accepts 32-bit instructions over a valid/ready stream and reads operands from a local 16×16 register file. It drives the ALU and captures its result and flags, writes the result back, and returns it over a valid/ready result stream. It sits between the instruction source (test harness or puzzle-specific fetch logic) and the ALU, serialising one instruction at a time.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_verilog.sv | 46 ++++
 rtl/alu_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU and its instruction sequencer.
// Op word layout: [15:12] class, [11:8] func, [7:0] immediate.
package alu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 16;

  localparam logic [3:0] CLASS_ALU = 4'h1;
  localparam logic [3:0] CLASS_LDI = 4'h2;

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;
  localparam logic [3:0] FN_AND = 4'h2;
  localparam logic [3:0] FN_OR  = 4'h3;
  localparam logic [3:0] FN_XOR = 4'h4;
  localparam logic [3:0] FN_NOT = 4'h5;
  localparam logic [3:0] FN_SHL = 4'h6;
  localparam logic [3:0] FN_SHR = 4'h7;
  localparam logic [3:0] FN_MUL = 4'h8;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  localparam int OP_LSB  = 16;
  localparam int RD_LSB  = 12;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 4;

  typedef struct packed {
    logic [15:0] op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rsvd;
  } instr_t;

endpackage

// File: rtl/alu_verilog.sv
// 16-bit combinational ALU with a 17-bit internal result.
// Flags are {2'b00, C, Z}; C is result bit 16.
module alu_verilog
  import alu_pkg::*;
(
  input  logic                  reset,
  input  logic [3:0]            func,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] c,
  output logic [3:0]            flags
);

  logic [DATA_WIDTH:0] ax;
  logic [DATA_WIDTH:0] bx;
  logic [DATA_WIDTH:0] r;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  always_comb begin
    r = '0;
    case (func)
      FN_ADD: r = ax + bx;
      FN_SUB: r = ax - bx;
      FN_AND: r = ax & bx;
      FN_OR:  r = ax | bx;
      FN_XOR: r = ax ^ bx;
      FN_NOT: r = {1'b0, ~a};
      FN_SHL: r = {a, 1'b0};
      FN_SHR: r = {2'b00, a[DATA_WIDTH-1:1]};
      FN_MUL: r = ax * bx;
      default: r = '0;
    endcase
    if (reset) r = '0;
  end

  assign c = r[DATA_WIDTH-1:0];

  always_comb begin
    flags = '0;
    flags[FLAG_C] = r[DATA_WIDTH];
    flags[FLAG_Z] = ~|r[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Serialises one instruction at a time through the ALU with a
// local 16x16 register file and valid/ready streams on both sides.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [3:0]            out_flags,
  input  logic [3:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_n;

  instr_t in_f;
  logic [15:0] ir_op_q;
  logic [3:0]  rd_q;
  logic [3:0]  ra_q;
  logic [3:0]  rb_q;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [15:0]           op_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [3:0]            flags_q;

  logic [DATA_WIDTH-1:0] alu_c;
  logic [3:0]            alu_flags;

  logic                  is_alu;
  logic                  is_ldi;
  logic                  exec_wr;
  logic [DATA_WIDTH-1:0] exec_res;
  logic                  take;

  logic unused_bits;

  assign in_f = instr_t'(in_instr);
  assign unused_bits = ^{in_f.rsvd, alu_flags[3:2]};

  alu_verilog u_alu (
    .reset (reset),
    .func  (op_q[11:8]),
    .a     (a_q),
    .b     (b_q),
    .c     (alu_c),
    .flags (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = READ;
      end
      READ: state_n = EXEC;
      EXEC: state_n = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign take   = in_valid && (state == IDLE);
  assign is_alu = (op_q[15:12] == CLASS_ALU);
  assign is_ldi = (op_q[15:12] == CLASS_LDI);

  always_comb begin
    exec_res = '0;
    exec_wr  = 1'b0;
    unique case (1'b1)
      is_alu: begin
        exec_res = alu_c;
        exec_wr  = 1'b1;
      end
      is_ldi: begin
        exec_res = {8'h00, op_q[7:0]};
        exec_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset wins over the EXEC write so a dropped op leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_op_q <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      if (take) begin
        ir_op_q <= in_f.op;
        rd_q    <= in_f.rd;
        ra_q    <= in_f.ra;
        rb_q    <= in_f.rb;
      end
      if (state == READ) begin
        a_q  <= regs[ra_q];
        b_q  <= regs[rb_q];
        op_q <= ir_op_q;
      end
      if (state == EXEC) begin
        res_q <= exec_res;
        if (exec_wr) regs[rd_q] <= exec_res;
        if (is_alu)
          flags_q <= {2'b00, alu_flags[1:0]};
      end
    end
  end

  assign out_result = res_q;
  assign out_flags  = flags_q;
  assign dbg_data   = regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised self-checking bench for alu_sequencer against an
// instruction-level reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_regs [16];
  logic        m_c;
  logic        m_z;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(
    input logic [3:0] cls, input logic [3:0] fn,
    input logic [7:0] imm, input logic [3:0] rd,
    input logic [3:0] ra, input logic [3:0] rb);
    logic [3:0] junk;
    junk = 4'($urandom);
    return {cls, fn, imm, rd, ra, rb, junk};
  endfunction

  // Reference ALU from plain integer arithmetic.
  task automatic ref_alu(input logic [3:0] fn,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         output logic [15:0] r,
                         output logic c);
    int unsigned w;
    r = '0;
    c = 1'b0;
    case (fn)
      4'd0: begin
        w = int'(a) + int'(b);
        r = w[15:0];
        c = (w > 32'd65535);
      end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << 1; c = a[15]; end
      4'd7: r = a >> 1;
      4'd8: begin
        w = int'(a) * int'(b);
        r = w[15:0];
        c = w[16];
      end
      default: begin r = '0; c = 1'b0; end
    endcase
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk(tag, dbg_data, m_regs[i]);
    end
  endtask

  task automatic run(input logic [31:0] ins, input int stall);
    logic [3:0]  cls;
    logic [3:0]  fn;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] er;
    logic        ec;
    int          waited;
    int          lat;
    cls = ins[31:28];
    fn  = ins[27:24];
    rd  = ins[15:12];
    a   = m_regs[ins[11:8]];
    b   = m_regs[ins[7:4]];
    er  = '0;
    if (cls == 4'h1) begin
      ref_alu(fn, a, b, er, ec);
      m_regs[rd] = er;
      m_c = ec;
      m_z = (er == 16'h0);
    end else if (cls == 4'h2) begin
      er = {8'h00, ins[23:16]};
      m_regs[rd] = er;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = $urandom;
    lat = 1;
    while (!out_valid && lat < 10) begin
      chk("busy_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 32'd3);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_res", out_result, er);
      @(negedge clk);
    end
    chk("result", out_result, er);
    chk("flags", out_flags, {30'd0, m_c, m_z});
    dbg_addr = rd;
    #1;
    chk("dbg_rd", dbg_data, m_regs[rd]);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("retire_valid", {31'd0, out_valid}, 32'd0);
    chk("retire_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic reset_in_exec(input logic [31:0] ins);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_novalid", {31'd0, out_valid}, 32'd0);
    end
    check_regs("rst_regs");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    dbg_addr  = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", out_flags, 32'd0);
    check_regs("rst_regs0");

    run(mk(4'h2, 4'h0, 8'h05, 4'd1, 4'd0, 4'd0), 0);
    run(mk(4'h2, 4'h0, 8'h03, 4'd2, 4'd0, 4'd0), 0);
    run(mk(4'h1, 4'h0, 8'h00, 4'd3, 4'd1, 4'd2), 0);
    chk("add_r3", m_regs[3], 32'h8);

    run(mk(4'h2, 4'h0, 8'h03, 4'd1, 4'd0, 4'd0), 0);
    run(mk(4'h2, 4'h0, 8'h05, 4'd2, 4'd0, 4'd0), 0);
    run(mk(4'h1, 4'h1, 8'h00, 4'd4, 4'd1, 4'd2), 0);
    chk("sub_borrow", out_flags, 32'b0010);
    run(mk(4'h1, 4'h1, 8'h00, 4'd5, 4'd2, 4'd2), 0);
    chk("sub_zero", out_flags, 32'b0001);

    run(mk(4'h2, 4'h0, 8'hFF, 4'd1, 4'd0, 4'd0), 0);
    for (int i = 0; i < 16; i++)
      run(mk(4'h1, 4'h6, 8'h00, 4'd1, 4'd1, 4'd0), 0);
    chk("shl_flags", out_flags, 32'b0011);
    run(mk(4'h1, 4'h5, 8'h00, 4'd6, 4'd0, 4'd0), 0);
    chk("not_r6", out_result, 32'hFFFF);

    run(mk(4'h1, 4'h0, 8'h00, 4'd8, 4'd0, 4'd0), 0);
    run(mk(4'h2, 4'h0, 8'h00, 4'd7, 4'd0, 4'd0), 0);
    chk("ldi_hold", out_flags, 32'b0001);
    run(mk(4'h0, 4'h3, 8'h5A, 4'd2, 4'd1, 4'd2), 0);
    chk("nop_hold", out_flags, 32'b0001);
    chk("nop_res", out_result, 32'h0);
    check_regs("nop_regs");

    run(mk(4'h1, 4'h0, 8'h00, 4'd9, 4'd6, 4'd6), 5);
    run(mk(4'h1, 4'hB, 8'h00, 4'd10, 4'd6, 4'd6), 0);
    run(mk(4'h1, 4'h8, 8'h00, 4'd11, 4'd6, 4'd6), 0);

    run(mk(4'h2, 4'h0, 8'h11, 4'd3, 4'd0, 4'd0), 0);
    reset_in_exec(mk(4'h1, 4'h0, 8'h00, 4'd3, 4'd3, 4'd3));

    for (int n = 0; n < 60; n++) begin
      logic [3:0] cls;
      int pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 6)      cls = 4'h1;
      else if (pick < 9) cls = 4'h2;
      else               cls = 4'($urandom);
      run(mk(cls, 4'($urandom), 8'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom)),
          int'($urandom_range(0, 3)));
      if (n % 10 == 9) check_regs("rand_regs");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
